// File: rtl/grad_val_diff_ctrl_if.sv
// Evaluator-side bus between grad_val_diff_ctrl (master) and the polynomial
// evaluator (slave): level start/done handshake with operand and result.
interface grad_val_diff_ctrl_if #(
  parameter int FUNC_W = 128
);
  logic              func_start;
  logic [31:0]       func_x;
  logic [FUNC_W-1:0] func_y;
  logic              func_done;

  modport master (
    output func_start,
    output func_x,
    input  func_y,
    input  func_done
  );

  modport slave (
    input  func_start,
    input  func_x,
    output func_y,
    output func_done
  );
endinterface

// File: rtl/grad_val_diff_ctrl.sv
// Drives the evaluator at x, x+h (and x-h) and forms f(x) plus a finite-difference f'(x).
// Optional feature macro GRAD_CENTRAL_DIFF_EN: central difference with three points.
module grad_val_diff_ctrl #(
  parameter int H_SHIFT = 4,
  parameter int FUNC_W  = 128
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [31:0]            x_in,
  grad_val_diff_ctrl_if.master   fbus,
  output logic [FUNC_W-1:0]      val_out,
  output logic [FUNC_W-1:0]      grad_out,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_REL  = 3'd4;
  localparam logic [2:0] S_CALC = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

`ifdef GRAD_CENTRAL_DIFF_EN
  localparam int NPTS = 3;
  localparam int SH   = 7 - H_SHIFT;  // 2h = 2^(H_SHIFT+1) LSB
`else
  localparam int NPTS = 2;
  localparam int SH   = 8 - H_SHIFT;
`endif
  localparam logic [1:0]  LAST_IDX = 2'(NPTS - 1);
  localparam logic [32:0] H_EXT    = 33'd1 << H_SHIFT;

  logic [2:0]        state;
  logic [1:0]        idx;
  logic [31:0]       x_reg;
  logic [31:0]       xp_reg;
  logic              ovf_sticky;
  logic [31:0]       point;
  logic [FUNC_W-1:0] y_reg [NPTS];

  logic [32:0] xp_sum;
  logic [31:0] xp_sat;
  logic        xp_ovf;

  assign xp_sum = {x_in[31], x_in} + H_EXT;
  assign xp_ovf = (xp_sum[32] != xp_sum[31]);
  assign xp_sat = xp_ovf ? 32'h7FFF_FFFF : xp_sum[31:0];

`ifdef GRAD_CENTRAL_DIFF_EN
  logic [31:0] xm_reg;
  logic [32:0] xm_sum;
  logic [31:0] xm_sat;
  logic        xm_ovf;

  assign xm_sum = {x_in[31], x_in} - H_EXT;
  assign xm_ovf = (xm_sum[32] != xm_sum[31]);
  assign xm_sat = xm_ovf ? 32'h8000_0000 : xm_sum[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      xm_reg <= '0;
    else if (state == S_LOAD)
      xm_reg <= xm_sat;
  end

  always_comb begin
    point = x_reg;
    case (idx)
      2'd1:    point = xp_reg;
      2'd2:    point = xm_reg;
      default: point = x_reg;
    endcase
  end
`else
  always_comb begin
    point = x_reg;
    if (idx == 2'd1)
      point = xp_reg;
  end
`endif

  // One capture register per sample point, written when that point's result arrives.
  generate
    for (genvar gi = 0; gi < NPTS; gi++) begin : g_y
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          y_reg[gi] <= '0;
        else if (state == S_WAIT && fbus.func_done && idx == 2'(gi))
          y_reg[gi] <= fbus.func_y;
      end
    end
  endgenerate

  logic signed [FUNC_W-1:0] y_hi;
  logic signed [FUNC_W-1:0] y_lo;
  logic signed [FUNC_W-1:0] diff;
  logic signed [FUNC_W-1:0] shifted;
  logic                     sub_ovf;
  logic                     shift_ovf;

  assign y_hi = y_reg[1];
`ifdef GRAD_CENTRAL_DIFF_EN
  assign y_lo = y_reg[2];
`else
  assign y_lo = y_reg[0];
`endif
  assign diff      = y_hi - y_lo;
  assign sub_ovf   = (y_hi[FUNC_W-1] != y_lo[FUNC_W-1]) && (diff[FUNC_W-1] != y_hi[FUNC_W-1]);
  assign shifted   = diff <<< SH;
  // Shifting back must reproduce the difference, else sign or significant bits were lost.
  assign shift_ovf = ((shifted >>> SH) != diff);

  assign busy = (state != S_IDLE) && (state != S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      idx             <= '0;
      x_reg           <= '0;
      xp_reg          <= '0;
      ovf_sticky      <= 1'b0;
      fbus.func_start <= 1'b0;
      fbus.func_x     <= '0;
      val_out         <= '0;
      grad_out        <= '0;
      overflow        <= 1'b0;
      done            <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_LOAD;
        S_LOAD: begin
          x_reg  <= x_in;
          xp_reg <= xp_sat;
`ifdef GRAD_CENTRAL_DIFF_EN
          ovf_sticky <= xp_ovf | xm_ovf;
`else
          ovf_sticky <= xp_ovf;
`endif
          idx   <= '0;
          state <= S_REQ;
        end
        S_REQ: begin
          // A stale done from the previous point must clear before a new request.
          if (!fbus.func_done) begin
            fbus.func_x     <= point;
            fbus.func_start <= 1'b1;
            state           <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (fbus.func_done) begin
            fbus.func_start <= 1'b0;
            state           <= S_REL;
          end
        end
        S_REL: begin
          if (!fbus.func_done) begin
            if (idx == LAST_IDX) begin
              state <= S_CALC;
            end else begin
              idx   <= idx + 2'd1;
              state <= S_REQ;
            end
          end
        end
        S_CALC: begin
          val_out  <= y_reg[0];
          grad_out <= shifted;
          overflow <= ovf_sticky | sub_ovf | shift_ovf;
          done     <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grad_val_diff_ctrl.sv
// Scoreboard bench for grad_val_diff_ctrl with a linear y = 3*x evaluator stub.
// Expectations follow GRAD_CENTRAL_DIFF_EN in the same way as the design.
module tb_grad_val_diff_ctrl;

  localparam int LAT = 6;
`ifdef GRAD_CENTRAL_DIFF_EN
  localparam int NPTS = 3;
`else
  localparam int NPTS = 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  x_in = '0;
  logic [127:0] val_out, grad_out;
  logic         busy, done, overflow;

  grad_val_diff_ctrl_if #(.FUNC_W(128)) fbus ();

  grad_val_diff_ctrl #(.H_SHIFT(4), .FUNC_W(128)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .fbus(fbus.master),
    .val_out(val_out), .grad_out(grad_out), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int extra_hold = 0;

  typedef struct packed {
    logic [127:0] v;
    logic [127:0] g;
    logic         o;
  } res_t;

  logic [31:0] fx_q [$];
  res_t        res_q [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Evaluator stub: samples x one cycle after start, answers LAT cycles later,
  // holds done until start falls plus extra_hold cycles.
  logic        stub_act;
  logic [3:0]  stub_cnt;
  logic [31:0] stub_x;
  int          hold_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_act       <= 1'b0;
      stub_cnt       <= '0;
      stub_x         <= '0;
      hold_cnt       <= 0;
      fbus.func_done <= 1'b0;
      fbus.func_y    <= '0;
    end else if (!stub_act && !fbus.func_done && fbus.func_start) begin
      stub_act <= 1'b1;
      stub_cnt <= '0;
    end else if (stub_act) begin
      stub_cnt <= stub_cnt + 4'd1;
      if (stub_cnt == 4'd0) stub_x <= fbus.func_x;
      if (stub_cnt == 4'(LAT - 1)) begin
        fbus.func_done <= 1'b1;
        fbus.func_y    <= {{96{stub_x[31]}}, stub_x} * 128'd3;
        stub_act       <= 1'b0;
        hold_cnt       <= 0;
      end
    end else if (fbus.func_done && !fbus.func_start) begin
      if (hold_cnt >= extra_hold) fbus.func_done <= 1'b0;
      else hold_cnt <= hold_cnt + 1;
    end
  end

  // Monitors: func_x per start pulse, results per done rise.
  logic prev_fs = 1'b0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (fbus.func_start && !prev_fs) begin
      pulses++;
      chk("start_while_done", {127'd0, fbus.func_done}, 128'd0);
      if (fx_q.size() == 0) begin
        errors++;
        $display("FAIL func_x: unexpected pulse with x=0x%0h", fbus.func_x);
      end else begin
        chk("func_x", {96'd0, fbus.func_x}, {96'd0, fx_q.pop_front()});
      end
    end
    if (done && !prev_done) begin
      if (res_q.size() == 0) begin
        errors++;
        $display("FAIL result: unexpected done");
      end else begin
        res_t r;
        r = res_q.pop_front();
        chk("val_out", val_out, r.v);
        chk("grad_out", grad_out, r.g);
        chk("overflow", {127'd0, overflow}, {127'd0, r.o});
      end
    end
    prev_fs   = fbus.func_start;
    prev_done = done;
  end

  task automatic push_exp(input logic [31:0] x, input logic [31:0] xp, input logic [31:0] xm,
                          input logic [127:0] v, input logic [127:0] g, input logic o);
    res_t r;
    fx_q.push_back(x);
    fx_q.push_back(xp);
    if (NPTS == 3) fx_q.push_back(xm);
    r.v = v; r.g = g; r.o = o;
    res_q.push_back(r);
  endtask

  task automatic run_req(input logic [31:0] x, input int hold_after);
    int base;
    bit seen;
    base = pulses;
    seen = 0;
    @(negedge clk);
    x_in  = x;
    start = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: x=0x%0h", x);
    end
    for (int n = 0; n < hold_after; n++) @(negedge clk);
    if (hold_after > 0) chk("done_held", {127'd0, done}, 128'd1);
    chk("pulse_count", 128'(pulses - base), 128'(NPTS));
    start = 1'b0;
    x_in  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("done_release", {127'd0, done}, 128'd0);
  endtask

  initial begin
    int base;
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_func_start", {127'd0, fbus.func_start}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_val", val_out, 128'd0);
    rst_n = 1'b1;

    push_exp(32'h0000_0100, 32'h0000_0110, 32'h0000_00F0, 128'h300, 128'h300, 1'b0);
    run_req(32'h0000_0100, 0);

    push_exp(32'hFFFF_FE00, 32'hFFFF_FE10, 32'hFFFF_FDF0, -128'sd1536, 128'h300, 1'b0);
    run_req(32'hFFFF_FE00, 0);

`ifdef GRAD_CENTRAL_DIFF_EN
    push_exp(32'h7FFF_FFF8, 32'h7FFF_FFFF, 32'h7FFF_FFE8, 128'h1_7FFF_FFE8, 128'h228, 1'b1);
    run_req(32'h7FFF_FFF8, 0);
    push_exp(32'h8000_0008, 32'h8000_0018, 32'h8000_0000, -128'sh1_7FFF_FFE8, 128'h240, 1'b1);
    run_req(32'h8000_0008, 0);
`else
    push_exp(32'h7FFF_FFF8, 32'h7FFF_FFFF, 32'h0, 128'h1_7FFF_FFE8, 128'h150, 1'b1);
    run_req(32'h7FFF_FFF8, 0);
    push_exp(32'h8000_0008, 32'h8000_0018, 32'h0, -128'sh1_7FFF_FFE8, 128'h300, 1'b0);
    run_req(32'h8000_0008, 0);
`endif

    // Evaluator keeps done high after start falls.
    extra_hold = 5;
    push_exp(32'h0000_0040, 32'h0000_0050, 32'h0000_0030, 128'hC0, 128'h300, 1'b0);
    run_req(32'h0000_0040, 0);
    extra_hold = 0;

    // Asynchronous reset during the second point's wait.
    push_exp(32'h0000_0200, 32'h0000_0210, 32'h0000_01F0, 128'h600, 128'h300, 1'b0);
    base = pulses;
    seen = 0;
    @(negedge clk);
    x_in  = 32'h0000_0200;
    start = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (pulses - base >= 2) begin seen = 1; break; end
    end
    if (!seen) begin
      errors++;
      $display("FAIL reset_setup_timeout: pulses=%0d", pulses - base);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_func_start", {127'd0, fbus.func_start}, 128'd0);
    chk("arst_busy", {127'd0, busy}, 128'd0);
    chk("arst_done", {127'd0, done}, 128'd0);
    chk("arst_val", val_out, 128'd0);
    chk("arst_grad", grad_out, 128'd0);
    fx_q.delete();
    res_q.delete();
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    push_exp(32'h0000_0100, 32'h0000_0110, 32'h0000_00F0, 128'h300, 128'h300, 1'b0);
    run_req(32'h0000_0100, 20);

    push_exp(32'h0000_0080, 32'h0000_0090, 32'h0000_0070, 128'h180, 128'h300, 1'b0);
    run_req(32'h0000_0080, 0);

    repeat (5) @(negedge clk);
    chk("fx_queue_empty", 128'(fx_q.size()), 128'd0);
    chk("res_queue_empty", 128'(res_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
